// File: rtl/stat_display_reader_if.sv
// Bus bundle for stat_display_reader: counter inputs, halt/capture controls
// and the multiplexed seven-segment outputs. The DUT uses the slave modport.
interface stat_display_reader_if;
  logic        halt;
  logic        capture;
  logic [31:0] total;
  logic [31:0] conditional;
  logic [31:0] unconditional;
  logic [31:0] conditional_success;
  logic [1:0]  sel;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [31:0] shown;
  logic [1:0]  cur_sel;
  logic        snap_valid;

  modport master (
    output halt, capture, total, conditional, unconditional, conditional_success, sel,
    input  seg, an, shown, cur_sel, snap_valid
  );

  modport slave (
    input  halt, capture, total, conditional, unconditional, conditional_success, sel,
    output seg, an, shown, cur_sel, snap_valid
  );
endinterface

// File: rtl/stat_display_reader.sv
// stat_display_reader: scans one of four 32-bit statistics counters onto an
// 8-digit multiplexed seven-segment display. A halt rising edge or a capture
// pulse freezes all four counters into a snapshot shown with the leftmost dp lit.
// The displayed value and counter index only change at frame boundaries.
// Optional feature macro: STAT_DISPLAY_AUTOROTATE_EN (cycle through counters
// automatically, ignoring sel).
module stat_display_reader #(
  parameter int SCAN_DIV      = 50000,
  parameter int ROTATE_FRAMES = 1024
) (
  input logic                  clk,
  input logic                  rst,
  stat_display_reader_if.slave bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  // Reject parameter values the scan and rotate logic cannot support.
  if (SCAN_DIV < 2 || ROTATE_FRAMES < 1) begin : g_paramCheck
    $error("stat_display_reader: SCAN_DIV must be >= 2 and ROTATE_FRAMES >= 1");
  end

  // Active-low gfedcba hex font.
  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    case (n)
      4'h0: hexGlyph = 7'b1000000;
      4'h1: hexGlyph = 7'b1111001;
      4'h2: hexGlyph = 7'b0100100;
      4'h3: hexGlyph = 7'b0110000;
      4'h4: hexGlyph = 7'b0011001;
      4'h5: hexGlyph = 7'b0010010;
      4'h6: hexGlyph = 7'b0000010;
      4'h7: hexGlyph = 7'b1111000;
      4'h8: hexGlyph = 7'b0000000;
      4'h9: hexGlyph = 7'b0010000;
      4'hA: hexGlyph = 7'b0001000;
      4'hB: hexGlyph = 7'b0000011;
      4'hC: hexGlyph = 7'b1000110;
      4'hD: hexGlyph = 7'b0100001;
      4'hE: hexGlyph = 7'b0000110;
      default: hexGlyph = 7'b0001110;
    endcase
  endfunction

  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic          r_haltD;
  logic [31:0]   r_snap [4];
  logic          r_snapValid;
  logic [31:0]   r_shown;
  logic [1:0]    r_curSel;
  logic [7:0]    r_an;
  logic [7:0]    r_seg;

  logic        w_tc;
  logic        w_frame;
  logic [2:0]  w_idxNext;
  logic        w_trig;
  logic        w_snapValidNext;
  logic [1:0]  w_selNext;
  logic [31:0] w_shownNext;
  logic [3:0]  w_nibble;
  logic        w_dpNext;

`ifdef STAT_DISPLAY_AUTOROTATE_EN
  localparam int RW = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
  localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_FRAMES - 1);

  logic [RW-1:0] r_rot;
  logic          w_rotLast;

  // Count completed frames so the counter index steps once per ROTATE_FRAMES frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rot <= '0;
    end else if (w_frame) begin
      r_rot <= w_rotLast ? '0 : r_rot + 1'b1;
    end
  end

  // Autorotate index selection: sel is ignored.
  always_comb begin
    w_rotLast = (r_rot == ROT_LAST);
    w_selNext = r_curSel;
    if (w_frame && w_rotLast) begin
      w_selNext = r_curSel + 2'd1;
    end
  end
`else
  // Manual index selection: sel is sampled only at the frame boundary.
  always_comb begin
    w_selNext = w_frame ? bus.sel : r_curSel;
  end
`endif

  // Next-state decode for scan position, snapshot control and displayed value.
  always_comb begin
    w_tc      = (r_div == DIV_LAST);
    w_frame   = w_tc && (r_idx == 3'd7);
    w_idxNext = w_tc ? r_idx + 3'd1 : r_idx;
    w_trig    = (bus.halt && !r_haltD) || bus.capture;

    w_snapValidNext = r_snapValid;
    if (w_trig) begin
      w_snapValidNext = 1'b1;
    end else if (!bus.halt && r_haltD) begin
      w_snapValidNext = 1'b0;
    end

    w_shownNext = r_shown;
    if (w_frame) begin
      if (r_snapValid) begin
        w_shownNext = r_snap[w_selNext];
      end else begin
        case (w_selNext)
          2'd0:    w_shownNext = bus.total;
          2'd1:    w_shownNext = bus.conditional;
          2'd2:    w_shownNext = bus.unconditional;
          default: w_shownNext = bus.conditional_success;
        endcase
      end
    end

    w_nibble = w_shownNext[{w_idxNext, 2'b00} +: 4];
    w_dpNext = ~((w_idxNext == 3'd7) && w_snapValidNext);
  end

  // Main state: divider, digit index, snapshot, frame-held value and registered drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_idx       <= 3'd0;
      r_haltD     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 32'd0;
      end
      r_snapValid <= 1'b0;
      r_shown     <= 32'd0;
      r_curSel    <= 2'd0;
      r_an        <= 8'b1111_1110;
      r_seg       <= 8'b1100_0000;
    end else begin
      r_div   <= w_tc ? '0 : r_div + 1'b1;
      r_idx   <= w_idxNext;
      r_haltD <= bus.halt;
      if (w_trig) begin
        r_snap[0] <= bus.total;
        r_snap[1] <= bus.conditional;
        r_snap[2] <= bus.unconditional;
        r_snap[3] <= bus.conditional_success;
      end
      r_snapValid <= w_snapValidNext;
      r_shown     <= w_shownNext;
      r_curSel    <= w_selNext;
      r_an        <= ~(8'b0000_0001 << w_idxNext);
      r_seg       <= {w_dpNext, hexGlyph(w_nibble)};
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.shown      = r_shown;
  assign bus.cur_sel    = r_curSel;
  assign bus.snap_valid = r_snapValid;

endmodule

// File: tb/tb_stat_display_reader.sv
// Testbench for stat_display_reader with SCAN_DIV=4, ROTATE_FRAMES=2.
// Directed steps plus a randomized phase, all checked against a cycle-count
// based reference model. Honors STAT_DISPLAY_AUTOROTATE_EN like the design.
module tb_stat_display_reader;
  localparam int SD    = 4;
  localparam int RF    = 2;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst;
  int   nTotal = 0;
  int   nBad   = 0;

  always #5 clk = ~clk;

  stat_display_reader_if bus();

  stat_display_reader #(.SCAN_DIV(SD), .ROTATE_FRAMES(RF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state: edges since reset, snapshot and frame-held value.
  int          mCyc;
  logic        mHaltD;
  logic        mSnapValid;
  logic [31:0] mSnap [4];
  logic [31:0] mShown;
  logic [1:0]  mCurSel;
  logic [6:0]  font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [31:0] liveVal(input logic [1:0] s);
    case (s)
      2'd0:    liveVal = bus.total;
      2'd1:    liveVal = bus.conditional;
      2'd2:    liveVal = bus.unconditional;
      default: liveVal = bus.conditional_success;
    endcase
  endfunction

  // Model update: frame boundary every FRAME edges, snapshot on halt rise or capture.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCyc = 0; mHaltD = 1'b0; mSnapValid = 1'b0; mShown = 32'd0; mCurSel = 2'd0;
      for (int i = 0; i < 4; i++) mSnap[i] = 32'd0;
    end else begin
      if ((mCyc + 1) % FRAME == 0) begin
`ifdef STAT_DISPLAY_AUTOROTATE_EN
        mCurSel = 2'(((mCyc + 1) / FRAME / RF) % 4);
`else
        mCurSel = bus.sel;
`endif
        mShown = mSnapValid ? mSnap[mCurSel] : liveVal(mCurSel);
      end
      if ((bus.halt && !mHaltD) || bus.capture) begin
        for (int i = 0; i < 4; i++) mSnap[i] = liveVal(2'(i));
        mSnapValid = 1'b1;
      end else if (!bus.halt && mHaltD) begin
        mSnapValid = 1'b0;
      end
      mHaltD = bus.halt;
      mCyc   = mCyc + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) else begin
      nBad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int         idx;
    logic [7:0] expAn;
    logic [7:0] expSeg;
    idx    = (mCyc / SD) % 8;
    expAn  = ~(8'b0000_0001 << idx);
    expSeg = {~((idx == 7) && mSnapValid), font[mShown[4*idx +: 4]]};
    checkVal({tag, ".an"},         32'(bus.an),         32'(expAn));
    checkVal({tag, ".seg"},        32'(bus.seg),        32'(expSeg));
    checkVal({tag, ".shown"},      bus.shown,           mShown);
    checkVal({tag, ".cur_sel"},    32'(bus.cur_sel),    32'(mCurSel));
    checkVal({tag, ".snap_valid"}, 32'(bus.snap_valid), 32'(mSnapValid));
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("run");
    end
  endtask

  task automatic waitBoundary();
    int k;
    k = 0;
    do begin
      applyStimulus(1);
      k++;
    end while ((mCyc % FRAME) != 0 && k < FRAME + 2);
    if ((mCyc % FRAME) != 0) checkVal("boundary_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDigit(input int d);
    int k;
    k = 0;
    while (((mCyc / SD) % 8) != d && k < FRAME + 2) begin
      applyStimulus(1);
      k++;
    end
    if (((mCyc / SD) % 8) != d) checkVal("digit_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.halt = 1'b0; bus.capture = 1'b0; bus.sel = 2'd0;
    bus.total = 32'h0000_00A8; bus.conditional = 32'd0;
    bus.unconditional = 32'd0; bus.conditional_success = 32'd0;
    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkVal("rst.an",    32'(bus.an),         32'h0000_00FE);
    checkVal("rst.seg",   32'(bus.seg),        32'h0000_00C0);
    checkVal("rst.shown", bus.shown,           32'd0);
    checkVal("rst.snap",  32'(bus.snap_valid), 32'd0);
    checkVal("rst.sel",   32'(bus.cur_sel),    32'd0);
    rst = 1'b0;

    $display("[TB] first frame");
    applyStimulus(32);
    checkVal("f1.shown", bus.shown,   32'h0000_00A8);
    checkVal("f1.an0",   32'(bus.an), 32'h0000_00FE);
    checkVal("f1.seg0",  32'(bus.seg), 32'h0000_0080);
    applyStimulus(4);
    checkVal("f1.an1",   32'(bus.an), 32'h0000_00FD);
    checkVal("f1.seg1",  32'(bus.seg), 32'h0000_0088);

    $display("[TB] halt snapshot");
    bus.total = 32'd100; bus.halt = 1'b1;
    applyStimulus(1);
    checkVal("halt.snap", 32'(bus.snap_valid), 32'd1);
    bus.total = 32'd105;
    waitBoundary();
`ifndef STAT_DISPLAY_AUTOROTATE_EN
    checkVal("halt.shown", bus.shown, 32'd100);
`endif
    waitDigit(7);
    checkVal("halt.dp", 32'(bus.seg[7]), 32'd0);

    $display("[TB] halt plus capture");
    bus.halt = 1'b0;
    applyStimulus(2);
    checkVal("unhalt.snap", 32'(bus.snap_valid), 32'd0);
    bus.sel = 2'd1; bus.conditional = 32'd7; bus.halt = 1'b1; bus.capture = 1'b1;
    applyStimulus(1);
    bus.capture = 1'b0; bus.conditional = 32'd9;
    waitBoundary();
`ifndef STAT_DISPLAY_AUTOROTATE_EN
    checkVal("cap.shown7", bus.shown, 32'd7);
`endif
    bus.capture = 1'b1;
    applyStimulus(1);
    bus.capture = 1'b0; bus.conditional = 32'd11;
    waitBoundary();
`ifndef STAT_DISPLAY_AUTOROTATE_EN
    checkVal("cap.shown9", bus.shown, 32'd9);
`endif

    $display("[TB] sel change mid-frame");
    bus.halt = 1'b0; bus.sel = 2'd0;
    bus.total = 32'h1234_5678; bus.conditional_success = 32'hCAFE_F00D;
    waitBoundary();
    applyStimulus(10);
    bus.sel = 2'd3;
    applyStimulus(5);
`ifndef STAT_DISPLAY_AUTOROTATE_EN
    checkVal("sel.hold", bus.shown, 32'h1234_5678);
`endif
    waitBoundary();
`ifndef STAT_DISPLAY_AUTOROTATE_EN
    checkVal("sel.new", bus.shown, 32'hCAFE_F00D);
`endif
    applyStimulus(8 * FRAME);

    $display("[TB] reset mid-snapshot");
    bus.halt = 1'b1;
    applyStimulus(1);
    waitDigit(5);
    checkVal("pre.snap", 32'(bus.snap_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkVal("mid.an",    32'(bus.an),         32'h0000_00FE);
    checkVal("mid.snap",  32'(bus.snap_valid), 32'd0);
    checkVal("mid.shown", bus.shown,           32'd0);
    bus.halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8);
    checkVal("post.snap0", 32'(bus.snap_valid), 32'd0);
    bus.halt = 1'b1;
    applyStimulus(1);
    checkVal("post.snap1", 32'(bus.snap_valid), 32'd1);

    $display("[TB] randomized phase");
    for (int i = 0; i < 600; i++) begin
      bus.total               = $urandom;
      bus.conditional         = $urandom;
      bus.unconditional       = $urandom;
      bus.conditional_success = $urandom;
      if ($urandom_range(0, 39) == 0) bus.halt = ~bus.halt;
      bus.capture = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 47) == 0) bus.sel = 2'($urandom_range(0, 3));
      applyStimulus(1);
    end
    bus.capture = 1'b0;
    applyStimulus(2);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule

// File: doc/stat_display_reader.md
STAT_DISPLAY_READER -- requirements
Module: stat_display_reader

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit is lit; minimum 2.
REQ-002 Parameter ROTATE_FRAMES, default 1024: full 8-digit frames per counter in auto-rotate mode.
REQ-003 clk  input  1  system clock; every state element is on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 halt  input  1  CPU halt level.
REQ-006 capture  input  1  manual snapshot request, one-cycle pulse.
REQ-007 total, conditional, unconditional, conditional_success  input  32 each  live statistics counters.
REQ-008 sel  input  2  counter select: 0 total, 1 conditional, 2 unconditional, 3 conditional_success.
REQ-009 seg  output  8  active-low segments: bit7 dp, bits6..0 g..a.
REQ-010 an  output  8  active-low digit enables, one-hot-low; bit0 is the rightmost digit.
REQ-011 shown  output  32  value currently displayed.
REQ-012 cur_sel  output  2  counter index currently displayed.
REQ-013 snap_valid  output  1  high while displaying frozen snapshot values.

Function
REQ-014 Snapshot trigger: rising edge of halt (halt=1 with registered halt_d=0) or capture=1.
- On trigger, all four counters are latched into snapshot registers in that same edge.
- snap_valid is set to 1 on that same edge.
REQ-015 Halt rise and capture in the same cycle: a single snapshot is taken.
- capture while snap_valid=1 re-latches the snapshot.
REQ-016 Falling edge of halt clears snap_valid on the next edge; snapshot contents are retained.
REQ-017 Display source:
- snap_valid=1: snapshot[cur_sel].
- snap_valid=0: live counter[cur_sel].
REQ-018 Divider counts 0..SCAN_DIV-1 and then wraps.
- At the terminal count, digit index advances 0..7 and wraps 7->0.
REQ-019 Frame boundary: the terminal count with digit index 7.
- At the frame boundary, shown and cur_sel are reloaded from the display source and the select logic.
- Between boundaries they are held, so one frame never shows mixed values.
REQ-020 Latency: a sel or snapshot change is reflected in shown at the next frame boundary, within 8*SCAN_DIV cycles.
REQ-021 an is low only at bit [digit index].
- seg[6:0] is the hex glyph of shown[4*idx+3:4*idx].
- an and seg are registered and change in the same cycle.
REQ-022 Glyphs (gfedcba, active low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the other nibbles use the standard hex font.
REQ-023 seg[7]=0 (dp lit) only when digit index=7 and snap_valid=1; otherwise seg[7]=1.

Reset
REQ-024 rst=1 clears the divider, digit index, rotate counter, snapshot registers, halt_d, shown, cur_sel and snap_valid to 0, asynchronously.
REQ-025 During reset, an=8'b11111110 and seg=8'b11000000 (digit 0 shows "0", dp off).
REQ-026 After reset deasserts, the first digit advance occurs SCAN_DIV cycles later.
- rst asserted mid-frame or mid-snapshot abandons the operation with no residual state.

Configuration
REQ-027 Macro STAT_DISPLAY_AUTOROTATE_EN, when defined:
- sel is ignored.
- cur_sel increments modulo 4 at the frame boundary ending every ROTATE_FRAMES-th frame; rotate counter wraps.
REQ-028 Macro STAT_DISPLAY_AUTOROTATE_EN, when undefined:
- cur_sel is sel sampled at the frame boundary.
- No rotate counter is instantiated.

Verification (SCAN_DIV=4, ROTATE_FRAMES=2)
REQ-029 Reset release, total=32'h0000_00A8, sel=0, halt=0.
- After the first frame boundary (32 cycles): shown=32'hA8.
- an walks FE,FD,...,7F, 4 cycles per digit.
- Digit 0 shows seg=8'b10000000 ("8"); digit 1 shows seg=8'b10001000 ("A").
REQ-030 halt rises while total=100 and then total increments to 105.
- snap_valid=1 on the next edge; shown=100 after the next frame boundary.
- Digit 7 shows seg[7]=0.
REQ-031 Same-cycle halt rise and capture with conditional=7.
- Exactly one snapshot, holding conditional=7.
- A later capture with conditional=9 updates the snapshot to 9.
REQ-032 sel changes 0->3 mid-frame.
- shown keeps the old value until the frame boundary, then equals conditional_success.
- Autorotate build: cur_sel cycles 0,1,2,3,0 every 2 frames.
REQ-033 rst pulsed at digit index 5 while snap_valid=1.
- Immediately: an=FE, snap_valid=0, shown=0.
- Afterwards, a fresh halt rise is required to freeze again.
